// File: rtl/mips_pkg.sv
// -----------------------------------------------------------------------------
// mips_pkg
// Shared datapath constants for the MIPS-style core. The register file, the
// issue stage and the ALU all read the architectural widths and the stack
// pointer location from here so they cannot drift apart.
//
// Contents:
//   RF_DATA_W  - architectural register width in bits
//   RF_ADDR_W  - register address width (depth = 2**RF_ADDR_W)
//   RF_SP_REG  - index of the stack-pointer register ($sp)
//   RF_SP_INIT - value $sp holds coming out of reset
//   is_zero_reg() - true for the hard-wired zero register
// -----------------------------------------------------------------------------
package mips_pkg;

  localparam int RF_DATA_W  = 32;
  localparam int RF_ADDR_W  = 5;
  localparam int RF_SP_REG  = 29;
  localparam int RF_SP_INIT = 1200;

  // Register 0 is hard-wired to zero: never written, never busy.
  function automatic logic is_zero_reg(input logic [RF_ADDR_W-1:0] idx);
    return idx == '0;
  endfunction

endpackage : mips_pkg

// File: rtl/regfile_scoreboard.sv
// -----------------------------------------------------------------------------
// regfile_scoreboard
// One busy bit per architectural register, plus a registered count of how
// many are set. A claim from issue marks a destination as having a pending
// producer; the matching writeback clears it.
//
// Ports:
//   clk       in   clock, state updates on rising edge
//   rst       in   asynchronous active-high reset, clears every busy bit
//   set_en    in   claim strobe from issue
//   set_reg   in   register being claimed
//   clr_en    in   writeback strobe
//   clr_reg   in   register being written back
//   busy      out  current busy vector (bit 0 is always 0)
//   busy_cnt  out  population count of busy, registered
// -----------------------------------------------------------------------------
module regfile_scoreboard
  import mips_pkg::*;
#(
  parameter int ADDR_W = RF_ADDR_W
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   set_en,
  input  logic [ADDR_W-1:0]      set_reg,
  input  logic                   clr_en,
  input  logic [ADDR_W-1:0]      clr_reg,
  output logic [(1<<ADDR_W)-1:0] busy,
  output logic [ADDR_W:0]        busy_cnt
);

  localparam int DEPTH = 1 << ADDR_W;

  logic [DEPTH-1:0] busy_q, busy_d;
  logic [ADDR_W:0]  busy_cnt_q, busy_cnt_d;

  // NOTE: every signal written in an always_comb gets a value before any
  // conditional assignment, otherwise the unassigned paths infer a latch.
  always_comb begin
    busy_d = busy_q;
    // Clear first, then set: when a new instruction claims the register
    // that is being written back this cycle, the new producer wins.
    if (clr_en) busy_d[clr_reg] = 1'b0;
    if (set_en) busy_d[set_reg] = 1'b1;
    busy_d[0] = 1'b0;

    // Count the next-state bits so the count lands on the same edge.
    busy_cnt_d = '0;
    for (int i = 0; i < DEPTH; i++) begin
      busy_cnt_d = busy_cnt_d + (ADDR_W+1)'(busy_d[i]);
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      busy_q     <= '0;
      busy_cnt_q <= '0;
    end else begin
      busy_q     <= busy_d;
      busy_cnt_q <= busy_cnt_d;
    end
  end

  assign busy     = busy_q;
  assign busy_cnt = busy_cnt_q;

endmodule : regfile_scoreboard

// File: rtl/regfile_sb.sv
// -----------------------------------------------------------------------------
// regfile_sb
// Architectural register file with NUM_RD combinational read ports, one
// writeback port, optional write-through forwarding, and a busy scoreboard
// that tracks registers with an outstanding producer.
//
// Ports:
//   clk        in   clock, state updates on rising edge
//   rst        in   asynchronous active-high reset
//   read_addr  in   NUM_RD x ADDR_W flattened read addresses (port k = slice k)
//   read_data  out  NUM_RD x DATA_W flattened read data (port k = slice k)
//   read_busy  out  bit k: register at read_addr[k] still has a pending write
//   write      in   writeback enable
//   writereg   in   writeback destination
//   writedata  in   writeback value
//   claim      in   issue-stage reservation strobe
//   claimreg   in   register being reserved
//   busy_cnt   out  number of registers currently busy
// -----------------------------------------------------------------------------
module regfile_sb
  import mips_pkg::*;
#(
  parameter int DATA_W  = RF_DATA_W,
  parameter int ADDR_W  = RF_ADDR_W,
  parameter int NUM_RD  = 2,          // legal range 1..4
  parameter int BYPASS  = 1,          // 1 = forward writedata to same-cycle reads
  parameter int SP_REG  = RF_SP_REG,
  parameter int SP_INIT = RF_SP_INIT
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NUM_RD*ADDR_W-1:0] read_addr,
  output logic [NUM_RD*DATA_W-1:0] read_data,
  output logic [NUM_RD-1:0]        read_busy,
  input  logic                     write,
  input  logic [ADDR_W-1:0]        writereg,
  input  logic [DATA_W-1:0]        writedata,
  input  logic                     claim,
  input  logic [ADDR_W-1:0]        claimreg,
  output logic [ADDR_W:0]          busy_cnt
);

  localparam int DEPTH = 1 << ADDR_W;

  logic [DATA_W-1:0] rf_q [DEPTH];
  logic [DATA_W-1:0] rf_d [DEPTH];
  logic              wr_en;
  logic [DEPTH-1:0]  busy;

  assign wr_en = write && !is_zero_reg(writereg);

  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      rf_d[i] = rf_q[i];
    end
    if (wr_en) rf_d[writereg] = writedata;
  end

  // NOTE: the array has an asynchronous reset to a defined value ($sp gets
  // its initial stack address), so it is built from flops rather than a
  // RAM macro, which cannot be cleared in one step.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        rf_q[i] <= (i == SP_REG && i != 0) ? DATA_W'(SP_INIT) : '0;
      end
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        rf_q[i] <= rf_d[i];
      end
    end
  end

  regfile_scoreboard #(
    .ADDR_W (ADDR_W)
  ) u_scoreboard (
    .clk      (clk),
    .rst      (rst),
    .set_en   (claim),
    .set_reg  (claimreg),
    .clr_en   (write),
    .clr_reg  (writereg),
    .busy     (busy),
    .busy_cnt (busy_cnt)
  );

  // Read ports. Forwarding is gated by rst so a write presented during
  // reset is not visible even combinationally.
  for (genvar k = 0; k < NUM_RD; k++) begin : g_rd
    logic [ADDR_W-1:0] addr;
    logic              fwd;

    assign addr = read_addr[k*ADDR_W +: ADDR_W];
    assign fwd  = (BYPASS != 0) && wr_en && !rst && (addr == writereg);

    assign read_data[k*DATA_W +: DATA_W] =
        is_zero_reg(addr) ? '0 :
        fwd               ? writedata :
                            rf_q[addr];

    // A forwarded register already has its value, so it no longer reads busy.
    assign read_busy[k] = busy[addr] && !fwd;
  end

endmodule : regfile_sb

// File: tb/tb_regfile_sb.sv
// -----------------------------------------------------------------------------
// tb_regfile_sb
// Directed bench for regfile_sb. Two instances share stimulus: one with
// forwarding, one without. Stimulus pushes expected values into a queue; a
// monitor pops and compares them on the falling edge.
// -----------------------------------------------------------------------------
module tb_regfile_sb;

  localparam int DW = 32;
  localparam int AW = 5;
  localparam int NR = 2;

  typedef enum {K_RD0, K_RD1, K_BUSY, K_CNT, K_NB_RD0, K_NB_BUSY} kind_e;

  typedef struct {
    string       name;
    kind_e       kind;
    logic [31:0] exp;
  } exp_t;

  logic              clk = 1'b0;
  logic              rst;
  logic [NR*AW-1:0]  rd_addr;
  logic [NR*DW-1:0]  rd_data, nb_rd_data;
  logic [NR-1:0]     rd_busy, nb_rd_busy;
  logic              write;
  logic [AW-1:0]     writereg;
  logic [DW-1:0]     writedata;
  logic              claim;
  logic [AW-1:0]     claimreg;
  logic [AW:0]       busy_cnt, nb_busy_cnt;

  exp_t sb_q[$];
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  regfile_sb #(.DATA_W(DW), .ADDR_W(AW), .NUM_RD(NR), .BYPASS(1),
               .SP_REG(29), .SP_INIT(1200)) dut (
    .clk(clk), .rst(rst), .read_addr(rd_addr), .read_data(rd_data),
    .read_busy(rd_busy), .write(write), .writereg(writereg),
    .writedata(writedata), .claim(claim), .claimreg(claimreg),
    .busy_cnt(busy_cnt)
  );

  regfile_sb #(.DATA_W(DW), .ADDR_W(AW), .NUM_RD(NR), .BYPASS(0),
               .SP_REG(29), .SP_INIT(1200)) dut_nb (
    .clk(clk), .rst(rst), .read_addr(rd_addr), .read_data(nb_rd_data),
    .read_busy(nb_rd_busy), .write(write), .writereg(writereg),
    .writedata(writedata), .claim(claim), .claimreg(claimreg),
    .busy_cnt(nb_busy_cnt)
  );

  // Monitor: compare every pending expectation against the settled outputs.
  initial begin
    exp_t        e;
    logic [31:0] act;
    forever begin
      @(negedge clk);
      while (sb_q.size() > 0) begin
        e = sb_q.pop_front();
        case (e.kind)
          K_RD0:     act = rd_data[31:0];
          K_RD1:     act = rd_data[63:32];
          K_BUSY:    act = {30'b0, rd_busy};
          K_CNT:     act = {26'b0, busy_cnt};
          K_NB_RD0:  act = nb_rd_data[31:0];
          K_NB_BUSY: act = {30'b0, nb_rd_busy};
          default:   act = 'x;
        endcase
        checks++;
        if (act !== e.exp) begin
          errors++;
          $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)",
                   e.name, act, e.exp, $time);
        end
      end
    end
  end

  task automatic check(input string name, input kind_e kind, input logic [31:0] exp);
    exp_t e;
    e.name = name;
    e.kind = kind;
    e.exp  = exp;
    sb_q.push_back(e);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_rd(input logic [AW-1:0] a0, input logic [AW-1:0] a1);
    rd_addr = {a1, a0};
  endtask

  task automatic drive(input logic w, input logic [AW-1:0] wr, input logic [DW-1:0] wd,
                       input logic c, input logic [AW-1:0] cr);
    write     = w;
    writereg  = wr;
    writedata = wd;
    claim     = c;
    claimreg  = cr;
  endtask

  initial begin
    logic [31:0] exp0, exp1;
    int          waited;

    rst = 1'b1;
    drive(0, 0, 0, 0, 0);
    set_rd(0, 0);
    tick();

    // Reset state, still in reset.
    set_rd(29, 0);
    check("rst_sp",   K_RD0,  32'd1200);
    check("rst_r0",   K_RD1,  32'd0);
    check("rst_busy", K_BUSY, 32'd0);
    check("rst_cnt",  K_CNT,  32'd0);
    tick();

    // Release reset and sweep every register on both ports.
    rst = 1'b0;
    for (int i = 0; i < 16; i++) begin
      set_rd(AW'(2*i), AW'(2*i+1));
      exp0 = (2*i   == 29) ? 32'd1200 : 32'd0;
      exp1 = (2*i+1 == 29) ? 32'd1200 : 32'd0;
      check($sformatf("sweep_r%0d", 2*i),   K_RD0, exp0);
      check($sformatf("sweep_r%0d", 2*i+1), K_RD1, exp1);
      check("sweep_busy", K_BUSY, 32'd0);
      tick();
    end

    // Writeback and register 0.
    drive(1, 5, 32'hDEADBEEF, 0, 0);
    set_rd(1, 2);
    check("w1_r1", K_RD0, 32'd0);
    tick();
    drive(1, 0, 32'h1234, 0, 0);
    set_rd(0, 5);
    check("w0_nofwd", K_RD0, 32'd0);
    check("w0_r5",    K_RD1, 32'hDEADBEEF);
    tick();
    drive(0, 0, 0, 0, 0);
    set_rd(5, 0);
    check("r5_kept", K_RD0, 32'hDEADBEEF);
    check("r0_zero", K_RD1, 32'd0);
    tick();

    // Bypass: reg7 claimed, then written while being read.
    drive(0, 0, 0, 1, 7);
    set_rd(7, 7);
    check("b1_busy", K_BUSY, 32'd0);
    check("b1_cnt",  K_CNT,  32'd0);
    tick();
    drive(1, 7, 32'h55, 0, 0);
    check("byp_rd0",     K_RD0,     32'h55);
    check("byp_rd1",     K_RD1,     32'h55);
    check("byp_busy",    K_BUSY,    32'd0);
    check("nobyp_rd0",   K_NB_RD0,  32'd0);
    check("nobyp_busy",  K_NB_BUSY, 32'd3);
    check("byp_cnt",     K_CNT,     32'd1);
    tick();
    drive(0, 0, 0, 0, 0);
    set_rd(7, 0);
    check("b3_rd0",    K_RD0,    32'h55);
    check("b3_nb_rd0", K_NB_RD0, 32'h55);
    check("b3_busy",   K_BUSY,   32'd0);
    check("b3_cnt",    K_CNT,    32'd0);
    tick();

    // Scoreboard set and clear.
    drive(0, 0, 0, 1, 9);
    set_rd(9, 9);
    check("c1_busy", K_BUSY, 32'd0);
    tick();
    drive(0, 0, 0, 0, 0);
    check("c2_busy",    K_BUSY,    32'd3);
    check("c2_cnt",     K_CNT,     32'd1);
    check("c2_nb_busy", K_NB_BUSY, 32'd3);
    tick();
    drive(1, 9, 32'h99, 0, 0);
    set_rd(9, 3);
    check("c3_rd0",     K_RD0,     32'h99);
    check("c3_busy",    K_BUSY,    32'd0);
    check("c3_nb_busy", K_NB_BUSY, 32'd1);
    check("c3_nb_rd0",  K_NB_RD0,  32'd0);
    check("c3_cnt",     K_CNT,     32'd1);
    tick();
    drive(0, 0, 0, 0, 0);
    set_rd(9, 9);
    check("c4_busy", K_BUSY, 32'd0);
    check("c4_cnt",  K_CNT,  32'd0);
    check("c4_rd0",  K_RD0,  32'h99);
    tick();

    // Claim and write of the same register in one cycle: busy stays set.
    drive(1, 9, 32'hAB, 1, 9);
    set_rd(9, 0);
    check("d1_cnt", K_CNT, 32'd0);
    check("d1_rd0", K_RD0, 32'hAB);
    tick();
    drive(0, 0, 0, 0, 0);
    set_rd(9, 9);
    check("d2_busy", K_BUSY, 32'd3);
    check("d2_cnt",  K_CNT,  32'd1);
    check("d2_rd0",  K_RD0,  32'hAB);
    check("d2_rd1",  K_RD1,  32'hAB);
    tick();
    drive(1, 9, 32'hAC, 0, 0);
    set_rd(1, 1);
    check("d3_cnt", K_CNT, 32'd1);
    tick();
    drive(0, 0, 0, 1, 0);
    set_rd(0, 9);
    check("d4_cnt",  K_CNT,  32'd0);
    check("d4_busy", K_BUSY, 32'd0);
    check("d4_rd0",  K_RD0,  32'd0);
    check("d4_rd1",  K_RD1,  32'hAC);
    tick();
    drive(0, 0, 0, 0, 0);
    set_rd(0, 0);
    check("claim_r0_cnt",  K_CNT,  32'd0);
    check("claim_r0_busy", K_BUSY, 32'd0);
    tick();

    // Reset mid-operation.
    drive(0, 0, 0, 1, 3);
    set_rd(3, 4);
    check("m1_cnt", K_CNT, 32'd0);
    tick();
    drive(0, 0, 0, 1, 4);
    check("m2_cnt",  K_CNT,  32'd1);
    check("m2_busy", K_BUSY, 32'd1);
    tick();
    drive(0, 0, 0, 1, 8);
    check("m3_cnt",  K_CNT,  32'd2);
    check("m3_busy", K_BUSY, 32'd3);
    tick();
    drive(0, 0, 0, 0, 0);
    set_rd(8, 29);
    check("m4_cnt",  K_CNT,  32'd3);
    check("m4_busy", K_BUSY, 32'd1);
    check("m4_sp",   K_RD1,  32'd1200);
    tick();
    // Assert reset between edges; results must show before the next edge.
    rst = 1'b1;
    drive(1, 5, 32'hFF, 1, 10);
    set_rd(5, 29);
    #1;
    check("arst_cnt",  K_CNT,  32'd0);
    check("arst_busy", K_BUSY, 32'd0);
    check("arst_r5",   K_RD0,  32'd0);
    check("arst_sp",   K_RD1,  32'd1200);
    tick();
    set_rd(5, 10);
    check("inrst_r5",  K_RD0, 32'd0);
    check("inrst_cnt", K_CNT, 32'd0);
    tick();
    rst = 1'b0;
    drive(0, 0, 0, 0, 0);
    set_rd(5, 29);
    check("post_r5",   K_RD0,  32'd0);
    check("post_sp",   K_RD1,  32'd1200);
    check("post_cnt",  K_CNT,  32'd0);
    check("post_busy", K_BUSY, 32'd0);
    tick();

    // Let the monitor drain, with a bound.
    waited = 0;
    while (sb_q.size() > 0 && waited < 10) begin
      @(negedge clk);
      #1;
      waited++;
    end
    checks++;
    if (sb_q.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d expectations left, expected 0", sb_q.size());
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule : tb_regfile_sb
